// File: rtl/flip_locator.sv
// +----------------------------------------------------------------------------+
// | flip_locator                                                               |
// | Serially scans i_a ^ i_b and reports the index of the single differing bit |
// | behind valid/ready handshakes; flags o_ERR on zero or multiple differences. |
// | Optional feature macro: FLIP_LOCATOR_EARLY_ABORT_EN (stop at second hit).  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module flip_locator #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_valid,
   output logic         o_ready,
   output logic [N-1:0] o_out,
   output logic         o_ERR,
   output logic         o_valid,
   input  logic         i_ready
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   diff_q, diff_d;
   logic [IW-1:0]  cnt_q, cnt_d;
   logic [1:0]     hits_q, hits_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [N-1:0]   out_q, out_d;
   logic           err_q, err_d;
   logic           valid_q, valid_d;
   logic           ready_q, ready_d;

   logic           bit_set;
   logic           last_bit;
   logic [1:0]     hits_nxt;
   logic [IW-1:0]  idx_nxt;

   always_comb begin
      state_d  = state_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      hits_d   = hits_q;
      idx_d    = idx_q;
      out_d    = out_q;
      err_d    = err_q;
      valid_d  = valid_q;

      bit_set  = diff_q[cnt_q];
      last_bit = (cnt_q == IW'(N - 1));
      hits_nxt = (bit_set && (hits_q != 2'd2)) ? hits_q + 2'd1 : hits_q;
      // Latch the position of the first set bit; later hits only bump the count.
      idx_nxt  = (bit_set && (hits_q == 2'd0)) ? cnt_q : idx_q;

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               diff_d  = i_a ^ i_b;
               cnt_d   = '0;
               hits_d  = 2'd0;
               err_d   = 1'b0;
               out_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            hits_d = hits_nxt;
            idx_d  = idx_nxt;
            cnt_d  = cnt_q + IW'(1);
`ifdef FLIP_LOCATOR_EARLY_ABORT_EN
            if (bit_set && (hits_q == 2'd1)) begin
               out_d   = '0;
               err_d   = 1'b1;
               valid_d = 1'b1;
               state_d = DONE;
            end else if (last_bit) begin
               out_d   = (hits_nxt == 2'd1) ? {{(N - IW){1'b0}}, idx_nxt} : '0;
               err_d   = (hits_nxt != 2'd1);
               valid_d = 1'b1;
               state_d = DONE;
            end
`else
            if (last_bit) begin
               out_d   = (hits_nxt == 2'd1) ? {{(N - IW){1'b0}}, idx_nxt} : '0;
               err_d   = (hits_nxt != 2'd1);
               valid_d = 1'b1;
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         diff_q  <= '0;
         cnt_q   <= '0;
         hits_q  <= 2'd0;
         idx_q   <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         hits_q  <= hits_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   assign o_ready = ready_q;
   assign o_out   = out_q;
   assign o_ERR   = err_q;
   assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_flip_locator.sv
// +----------------------------------------------------------------------------+
// | tb_flip_locator                                                            |
// | Directed vector table plus handshake corner sequences for flip_locator.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_flip_locator;

   localparam int N = 8;
`ifdef FLIP_LOCATOR_EARLY_ABORT_EN
   localparam int EA = 1;
`else
   localparam int EA = 0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] a, b;
   logic         in_valid;
   logic         out_ready;
   logic         dut_ready;
   logic [N-1:0] dut_out;
   logic         dut_err;
   logic         dut_valid;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] out;
      logic       err;
      int         lat;
   } vec_t;

   vec_t vecs[9];

   flip_locator #(.N(N)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_a     (a),
      .i_b     (b),
      .i_valid (in_valid),
      .o_ready (dut_ready),
      .o_out   (dut_out),
      .o_ERR   (dut_err),
      .o_valid (dut_valid),
      .i_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Counts edges from the accept edge until o_valid is seen; capped at 40.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!dut_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] eo,
                          input logic ee, input int el, input string nm);
      int lat;
      @(negedge clk);
      a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b0;
      check({nm, " idle_ready"}, 32'(dut_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({nm, " busy_ready"}, 32'(dut_ready), 32'd0);
      wait_valid(lat);
      check({nm, " latency"}, 32'(lat), 32'(el));
      check({nm, " out"}, 32'(dut_out), 32'(eo));
      check({nm, " err"}, 32'(dut_err), 32'(ee));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({nm, " handoff_valid"}, 32'(dut_valid), 32'd0);
      check({nm, " handoff_ready"}, 32'(dut_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;

      vecs[0] = '{8'h00, 8'h20, 8'h05, 1'b0, 8};
      vecs[1] = '{8'h80, 8'h00, 8'h07, 1'b0, 8};
      vecs[2] = '{8'hA5, 8'hA5, 8'h00, 1'b1, 8};
      vecs[3] = '{8'h0F, 8'h0C, 8'h00, 1'b1, (EA != 0) ? 2 : 8};
      vecs[4] = '{8'h00, 8'h01, 8'h00, 1'b0, 8};
      vecs[5] = '{8'h3C, 8'h34, 8'h03, 1'b0, 8};
      vecs[6] = '{8'h00, 8'h81, 8'h00, 1'b1, 8};
      vecs[7] = '{8'h00, 8'h30, 8'h00, 1'b1, (EA != 0) ? 6 : 8};
      vecs[8] = '{8'hFF, 8'h00, 8'h00, 1'b1, (EA != 0) ? 2 : 8};

      rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", 32'(dut_ready), 32'd1);
      check("reset valid", 32'(dut_valid), 32'd0);
      check("reset out", 32'(dut_out), 32'd0);
      check("reset err", 32'(dut_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++)
         run_txn(vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));

      // Backpressure: result held while a stray request is presented.
      @(negedge clk);
      a = 8'h00; b = 8'h08; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(lat);
      check("bp latency", 32'(lat), 32'd8);
      a = 8'h01; b = 8'h00; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp hold%0d valid", c), 32'(dut_valid), 32'd1);
         check($sformatf("bp hold%0d out", c), 32'(dut_out), 32'h03);
         check($sformatf("bp hold%0d err", c), 32'(dut_err), 32'd0);
         check($sformatf("bp hold%0d ready", c), 32'(dut_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp release valid", 32'(dut_valid), 32'd0);
      check("bp release ready", 32'(dut_ready), 32'd1);
      check("bp out kept", 32'(dut_out), 32'h03);
      @(posedge clk);
      #1;
      check("bp no capture", 32'(dut_ready), 32'd1);

      // Reset asserted while scanning.
      @(negedge clk);
      a = 8'h00; b = 8'h20; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst ready", 32'(dut_ready), 32'd1);
      check("midrst valid", 32'(dut_valid), 32'd0);
      check("midrst out", 32'(dut_out), 32'd0);
      check("midrst err", 32'(dut_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_txn(8'h00, 8'h02, 8'h01, 1'b0, 8, "after_rst");

      // Back-to-back with i_valid and i_ready held high.
      @(negedge clk);
      a = 8'h00; b = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      a = 8'h00; b = 8'h40;
      check("b2b first accept", 32'(dut_ready), 32'd0);
      wait_valid(lat);
      check("b2b first latency", 32'(lat), 32'd8);
      check("b2b first out", 32'(dut_out), 32'h04);
      check("b2b first err", 32'(dut_err), 32'd0);
      @(posedge clk);
      #1;
      check("b2b handoff valid", 32'(dut_valid), 32'd0);
      check("b2b handoff ready", 32'(dut_ready), 32'd1);
      @(posedge clk);
      #1;
      check("b2b second accept", 32'(dut_ready), 32'd0);
      in_valid = 1'b0;
      wait_valid(lat);
      check("b2b second latency", 32'(lat), 32'd8);
      check("b2b second out", 32'(dut_out), 32'h06);
      check("b2b second err", 32'(dut_err), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("b2b end valid", 32'(dut_valid), 32'd0);
      check("b2b end ready", 32'(dut_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/flip_locator.md
Name: flip_locator

Overview:
- Inverse of the single-bit toggler: given an original word and a modified word, finds the index of the one bit that differs.
- Scans the XOR difference serially, one bit per clock, behind a valid/ready handshake on both input and output.
- Reports the index in the toggler's bit-select format: N bits, MSB is the sign bit and always 0, lower bits are the index.
- Flags an error if zero bits or more than one bit differ.

Parameters:
- N, 8, operand width and index-word width; N >= 2.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_a  input  N  original word.
- i_b  input  N  modified word.
- i_valid  input  1  operands valid.
- o_ready  output  1  block idle and able to accept operands.
- o_out  output  N  located bit index; MSB always 0.
- o_ERR  output  1  zero or multiple bits differ.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.

Behaviour:
- Reset values: state IDLE, o_ready=1, o_valid=0, o_out=0, o_ERR=0.
- Internal registers:
  - diff register: N bits.
  - bit counter cnt: $clog2(N) bits.
  - hit counter: 2 bits, saturating at 2.
  - index register: $clog2(N) bits.
- All outputs are registered. o_ready = (state==IDLE).
- IDLE:
  - On i_valid && o_ready at an edge: diff <= i_a ^ i_b, cnt <= 0, hits <= 0, o_ERR <= 0, o_out <= 0; go to SCAN.
  - i_a and i_b are sampled only at this edge.
- SCAN:
  - Each edge examines diff[cnt].
  - If set: hits increments (saturating at 2), and on the first hit the index register <= cnt.
  - cnt increments each edge.
  - At the edge where cnt==N-1 the scan ends and the state goes to DONE.
  - SCAN lasts exactly N cycles; o_valid rises N cycles after the accept edge.
- DONE entry:
  - Final hits computed including the last examined bit.
  - Exactly one hit: o_out <= {1'b0, zero-extended index}, o_ERR <= 0.
  - Otherwise: o_out <= 0, o_ERR <= 1.
  - o_valid <= 1.
- DONE:
  - o_valid, o_out and o_ERR stay stable while i_ready=0.
  - On i_ready=1 at an edge: o_valid <= 0, go to IDLE.
  - o_ready rises the cycle after the handoff; there is no same-cycle re-accept.
  - o_out and o_ERR keep their last values until the next accept.
- i_valid is ignored in SCAN and DONE. Operands presented then are not captured and must be held by the producer.
- Index N-1 (MSB) is a legal result. o_out's MSB is never set.
- i_rst in any state (mid-SCAN or DONE) returns to reset values at that edge; the pending result is discarded.
- i_rst takes priority over a simultaneous i_valid or i_ready.

Optional Feature:
- Macro: FLIP_LOCATOR_EARLY_ABORT_EN.
- Defined:
  - In SCAN, the edge on which a second set bit is detected ends the scan immediately and enters DONE with o_ERR=1, o_out=0.
  - o_valid rises k+1 cycles after the accept edge, where k is the index of the second differing bit.
  - Single-hit and zero-hit cases keep N-cycle latency.
- Undefined: the scan always runs all N bits; latency is fixed at N cycles for every case.

Test Plan (N=8):
1. Single flip: i_a=8'h00, i_b=8'h20, i_valid pulse -> o_valid high 8 cycles after accept, o_out=8'h05, o_ERR=0; handoff with i_ready=1 -> o_ready=1 next cycle.
2. MSB flip, no difference:
   - i_a=8'h80, i_b=8'h00 -> o_out=8'h07, o_ERR=0.
   - i_a=i_b=8'hA5 -> o_out=0, o_ERR=1, latency 8.
3. Multiple flips: i_a=8'h0F, i_b=8'h0C (bits 0,1 differ) -> o_ERR=1, o_out=0.
   - Without macro: latency 8.
   - With FLIP_LOCATOR_EARLY_ABORT_EN: o_valid 2 cycles after accept.
4. Backpressure: result 8'h03 held with i_ready=0 for 5 cycles -> o_valid, o_out and o_ERR stable; a new i_valid with i_a=8'h01, i_b=8'h00 during that time is ignored (o_ready=0).
5. Reset mid-scan:
   - Assert i_rst at SCAN cycle 4 -> next cycle o_ready=1, o_valid=0, o_out=0, o_ERR=0.
   - A following i_a=8'h00, i_b=8'h02 -> o_out=8'h01 after 8 cycles.
6. Back-to-back: two operand pairs (8'h00/8'h10, then 8'h00/8'h40) presented with i_valid held high and i_ready=1 -> results o_out=8'h04 then 8'h06.
   - Second accept on the first cycle o_ready returns high; no operand loss.
